// File: rtl/big_adder_pkg.sv
// Shared definitions for the pipelined multi-precision adder: default slice
// width, add/sub mode encoding and the stage-count helper used to size and
// validate the pipeline.
package big_adder_pkg;

  // Bits resolved per pipeline stage when the instantiating block does not override it
  localparam int DEFAULT_CHUNK = 16;

  // Mode encoding carried with every beat
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of pipeline stages for a WIDTH/CHUNK pair.
  // Returns 0 for an unusable combination so the top can refuse to elaborate.
  function automatic int stage_count(input int width, input int chunk);
    if (chunk < 1 || chunk > width) begin
      return 0;
    end
    if ((width % chunk) != 0) begin
      return 0;
    end
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One slice of the pipelined adder. It adds slice IDX of the two effective
// operands using the carry registered by the previous stage, merges the new
// sum bits into the partial sum, and passes operands and mode down the pipe.
// Every register moves only when the pipeline advances; reset clears the
// valid bit only, the datapath registers are don't-care while invalid.
module adder_chunk_stage
  import big_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = DEFAULT_CHUNK,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  input  logic             up_sub,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             sub
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] sum_next;

  // Resolve this stage's slice and splice it into the partial sum; lower
  // slices already resolved upstream are passed through untouched
  always_comb begin
    slice    = {1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]}
             + {{CHUNK{1'b0}}, up_carry};
    sum_next = up_sum;
    sum_next[LO +: CHUNK] = slice[CHUNK-1:0];
  end

  // Valid bit: cleared by reset, shifted along with the pipeline otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= up_valid;
    end
  end

  // Datapath registers: hold while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (advance) begin
      a     <= up_a;
      b     <= up_b;
      sum   <= sum_next;
      carry <= slice[CHUNK];
      sub   <= up_sub;
    end
  end

endmodule

// File: rtl/pipelined_big_adder.sv
// Pipelined WIDTH-bit add/subtract unit. Operands are split into CHUNK-bit
// slices and one slice is resolved per stage, so no carry chain is longer
// than CHUNK bits per clock. A single advance signal shifts the whole pipe
// (bubbles included) whenever the output register is empty or being drained.
// Subtraction is done as A + ~B + ~borrow_in, and the final stage converts
// the carry back into a borrow.
module pipelined_big_adder
  import big_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);
  // Keeps the arrays below well-formed while the parameter check reports the error
  localparam int DEPTH  = (STAGES < 1) ? 1 : STAGES;

  if (STAGES < 1) begin : g_param_check
    $error("pipelined_big_adder: WIDTH must be a positive multiple of CHUNK");
  end

  logic             advance;
  logic             v_pipe [0:DEPTH];
  logic [WIDTH-1:0] a_pipe [0:DEPTH];
  logic [WIDTH-1:0] b_pipe [0:DEPTH];
  logic [WIDTH-1:0] s_pipe [0:DEPTH];
  logic             c_pipe [0:DEPTH];
  logic             m_pipe [0:DEPTH];

  assign advance  = !v_pipe[DEPTH] || out_ready;
  assign in_ready = advance;

  // Entry point of the pipe: stage 0 sees the effective operands and carry
  assign v_pipe[0] = in_valid;
  assign a_pipe[0] = a_in;
  assign b_pipe[0] = (sub == MODE_SUB) ? ~b_in : b_in;
  assign s_pipe[0] = '0;
  assign c_pipe[0] = (sub == MODE_SUB) ? ~c_in : c_in;
  assign m_pipe[0] = sub;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    adder_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (advance),
      .up_valid (v_pipe[k]),
      .up_a     (a_pipe[k]),
      .up_b     (b_pipe[k]),
      .up_sum   (s_pipe[k]),
      .up_carry (c_pipe[k]),
      .up_sub   (m_pipe[k]),
      .valid    (v_pipe[k+1]),
      .a        (a_pipe[k+1]),
      .b        (b_pipe[k+1]),
      .sum      (s_pipe[k+1]),
      .carry    (c_pipe[k+1]),
      .sub      (m_pipe[k+1])
    );
  end

  logic msb_carry_in;

  // Result formation: borrow conversion for subtract, signed overflow from the
  // carries around the MSB of the effective operands, outputs zero when idle
  always_comb begin
    out_valid    = v_pipe[DEPTH];
    msb_carry_in = a_pipe[DEPTH][WIDTH-1] ^ b_pipe[DEPTH][WIDTH-1]
                 ^ s_pipe[DEPTH][WIDTH-1];
    s_out        = '0;
    c_out        = 1'b0;
    ovf          = 1'b0;
    if (out_valid) begin
      s_out = s_pipe[DEPTH];
      c_out = (m_pipe[DEPTH] == MODE_SUB) ? ~c_pipe[DEPTH] : c_pipe[DEPTH];
      ovf   = msb_carry_in ^ c_pipe[DEPTH];
    end
  end

endmodule

// File: tb/tb_pipelined_big_adder.sv
// Self-checking bench for pipelined_big_adder: directed vectors, backpressure,
// mid-flight reset, a randomized stream against an arithmetic reference model,
// and two parameter variants.
module tb_pipelined_big_adder;

  localparam int W = 64;
  localparam int STAGES = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          sub;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s_out;
  logic          c_out;
  logic          ovf;

  logic          v_in_valid;
  logic [31:0]   v_a;
  logic [31:0]   v_b;
  logic          v_sub;
  logic          v_cin;
  logic          v8_in_ready, v8_out_valid, v8_c_out, v8_ovf;
  logic [31:0]   v8_s_out;
  logic          v1_in_ready, v1_out_valid, v1_c_out, v1_ovf;
  logic [31:0]   v1_s_out;

  int            assertCount = 0;
  int            failCount = 0;
  logic [65:0]   expQ [$];
  logic [65:0]   heldVal;
  bit            holding = 0;
  bit            streamDone;

  pipelined_big_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .c_out(c_out), .ovf(ovf)
  );

  pipelined_big_adder #(.WIDTH(32), .CHUNK(8)) dut32x8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v8_in_ready),
    .a_in(v_a), .b_in(v_b), .sub(v_sub), .c_in(v_cin),
    .out_valid(v8_out_valid), .out_ready(1'b1),
    .s_out(v8_s_out), .c_out(v8_c_out), .ovf(v8_ovf)
  );

  pipelined_big_adder #(.WIDTH(32), .CHUNK(32)) dut32x32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v1_in_ready),
    .a_in(v_a), .b_in(v_b), .sub(v_sub), .c_in(v_cin),
    .out_valid(v1_out_valid), .out_ready(1'b1),
    .s_out(v1_s_out), .c_out(v1_c_out), .ovf(v1_ovf)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: exact integer arithmetic, packed as {ovf, c_out, s_out}
  function automatic logic [65:0] refResult(input logic [63:0] a, input logic [63:0] b,
                                            input logic s, input logic c);
    logic [64:0]        wide;
    logic signed [65:0] sa, sb, sc, sr, sFit;
    if (!s) wide = {1'b0, a} + {1'b0, b} + {64'd0, c};
    else    wide = {1'b0, a} - {1'b0, b} - {64'd0, c};
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    sc = {65'd0, c};
    sr = s ? (sa - sb - sc) : (sa + sb + sc);
    sFit = {{2{wide[63]}}, wide[63:0]};
    return {(sr != sFit), wide[64], wide[63:0]};
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [65:0] got, input logic [65:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one beat from a negedge and hold it until accepted; returns at the
  // negedge after the accepting edge with in_valid dropped
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic s, input logic c);
    int waitCycles = 0;
    a_in = a;
    b_in = b;
    sub = s;
    c_in = c;
    in_valid = 1'b1;
    #4;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      #4;
      waitCycles++;
    end
    if (!in_ready) checkOutput("accept timeout", 66'd0, 66'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the lone in-flight result of a directed beat and check it and its latency
  task automatic waitResult(input string tag, input logic [65:0] exp);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s latency", tag), 66'(n), 66'(STAGES));
    checkOutput(tag, {ovf, c_out, s_out}, exp);
  endtask

  // Scoreboard: just before each rising edge, retire transferring results in
  // order, check stability under stall, and log accepted beats into the model
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        expQ.delete();
        holding = 0;
      end else begin
        if (out_valid) begin
          if (holding) checkOutput("hold stable", {ovf, c_out, s_out}, heldVal);
          if (expQ.size() == 0) begin
            checkOutput("spurious out_valid", 66'(out_valid), 66'd0);
          end else if (out_ready) begin
            checkOutput("stream result", {ovf, c_out, s_out}, expQ.pop_front());
          end
          holding = !out_ready;
          heldVal = {ovf, c_out, s_out};
        end else begin
          holding = 0;
        end
        if (in_valid && in_ready) expQ.push_back(refResult(a_in, b_in, sub, c_in));
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    int lat8, lat1;
    logic [33:0] res8, res1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_in = '0;
    b_in = '0;
    sub = 1'b0;
    c_in = 1'b0;
    v_in_valid = 1'b0;
    v_a = '0;
    v_b = '0;
    v_sub = 1'b0;
    v_cin = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", 66'(out_valid), 66'd0);
    checkOutput("reset outputs", {ovf, c_out, s_out}, 66'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", 66'(in_ready), 66'd1);

    // Directed vectors
    applyStimulus(64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1'b0, 1'b0);
    waitResult("add no carry", {1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF});
    @(negedge clk);
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b1);
    waitResult("full ripple", {1'b0, 1'b1, 64'h0});
    @(negedge clk);
    applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0);
    waitResult("signed ovf add", {1'b1, 1'b0, 64'h8000000000000000});
    @(negedge clk);
    applyStimulus(64'h0, 64'h1, 1'b1, 1'b0);
    waitResult("sub borrow", {1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF});
    @(negedge clk);
    // E2A1E2A1_E2A1E2A1 - DEADBEAF_00000000 - 1, worked by hand
    applyStimulus(64'hE2A1E2A1E2A1E2A1, 64'hDEADBEAF00000000, 1'b1, 1'b1);
    waitResult("sub borrow-in", {1'b0, 1'b0, 64'h03F423F2E2A1E2A0});
    @(negedge clk);
    applyStimulus(64'h8000000000000000, 64'h1, 1'b1, 1'b0);
    waitResult("signed ovf sub", {1'b1, 1'b0, 64'h7FFFFFFFFFFFFFFF});
    @(negedge clk);

    // Backpressure: six back-to-back beats, downstream stalls for four cycles
    streamDone = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'(i % 2), 1'(i / 3));
        end
        streamDone = 1;
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        checkOutput("full pipe in_ready", 66'(in_ready), 66'd0);
        checkOutput("full pipe out_valid", 66'(out_valid), 66'd1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    seen = 0;
    while (expQ.size() != 0 && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("backpressure drained", 66'(expQ.size()), 66'd0);
    @(negedge clk);

    // Reset with three beats in flight
    applyStimulus(64'h1111, 64'h2222, 1'b0, 1'b0);
    applyStimulus(64'h3333, 64'h4444, 1'b1, 1'b0);
    applyStimulus(64'h5555, 64'h6666, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid reset out_valid", 66'(out_valid), 66'd0);
    checkOutput("mid reset in_ready", 66'(in_ready), 66'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("flushed beats never emitted", 66'(seen), 66'd0);

    // Randomized stream with random gaps and random downstream stalls
    streamDone = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [63:0] ra, rb;
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          if ($urandom_range(0, 7) == 0) ra = '1;
          if ($urandom_range(0, 7) == 0) rb = {1'b0, {63{1'b1}}};
          repeat ($urandom_range(0, 2)) @(negedge clk);
          applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        streamDone = 1;
      end
      begin
        while (!streamDone) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    seen = 0;
    while (expQ.size() != 0 && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("random drained", 66'(expQ.size()), 66'd0);

    // Parameter variants: WIDTH=32 with CHUNK=8 and CHUNK=32
    @(negedge clk);
    checkOutput("v8 idle in_ready", 66'(v8_in_ready), 66'd1);
    v_a = 32'hFFFF0000;
    v_b = 32'h0000FFFF;
    v_sub = 1'b0;
    v_cin = 1'b1;
    v_in_valid = 1'b1;
    @(negedge clk);
    v_in_valid = 1'b0;
    lat8 = 0;
    lat1 = 0;
    res8 = '0;
    res1 = '0;
    for (int i = 1; i <= 12; i++) begin
      if (v8_out_valid && lat8 == 0) begin
        lat8 = i;
        res8 = {v8_ovf, v8_c_out, v8_s_out};
      end
      if (v1_out_valid && lat1 == 0) begin
        lat1 = i;
        res1 = {v1_ovf, v1_c_out, v1_s_out};
      end
      @(negedge clk);
    end
    checkOutput("chunk8 latency", 66'(lat8), 66'd4);
    checkOutput("chunk8 result", 66'(res8), 66'({1'b0, 1'b1, 32'h00000000}));
    checkOutput("chunk32 latency", 66'(lat1), 66'd1);
    checkOutput("chunk32 result", 66'(res1), 66'({1'b0, 1'b1, 32'h00000000}));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
